// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// The dump FSM states live here so the core top and debug logic can name them.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: writes clear, issue marks set (mark wins), lookup per read port.
// Register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [NWR-1:0]    clr_en,
    input  logic [NWR*AW-1:0] clr_num,
    input  logic              mark_en,
    input  logic [AW-1:0]     mark_num,
    input  logic [NRD*AW-1:0] rd_num,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // The mark is applied after the clears because it stands for a newer producer.
    always_comb begin
        busy_next = busy;
        for (int p = 0; p < NWR; p++) begin
            if (clr_en[p]) begin
                busy_next[clr_num[p*AW +: AW]] = 1'b0;
            end
        end
        if (mark_en) begin
            busy_next[mark_num] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy[rd_num[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write bypass, busy scoreboard
// and a hardware dump engine that streams every register out once the core halts.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [NRD*AW-1:0]   rd_num,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_we,
    input  logic [NWR*AW-1:0]   wr_num,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                mark_en,
    input  logic [AW-1:0]       mark_num,
    input  logic                halted,
    output logic                dump_valid,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_done
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    dump_state_t                state;
    dump_state_t                state_next;
    logic [AW-1:0]              cnt;
    logic                       active;
    logic [NWR-1:0]             wr_eff;
    logic                       mark_eff;

    // Writes and marks only take effect in IDLE so a dump sees a frozen snapshot.
    assign active   = (state == IDLE);
    assign mark_eff = active && mark_en && (mark_num != '0);

    always_comb begin
        wr_eff = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_eff[p] = active && wr_we[p] && (wr_num[p*AW +: AW] != '0);
        end
    end

    // Later ports overwrite earlier ones, so the highest-indexed port wins.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            regs <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_eff[p]) begin
                    regs[wr_num[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = regs[rd_num[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_eff[p] && (wr_num[p*AW +: AW] == rd_num[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst_b    (rst_b),
        .clr_en   (wr_eff),
        .clr_num  (wr_num),
        .mark_en  (mark_eff),
        .mark_num (mark_num),
        .rd_num   (rd_num),
        .rd_busy  (rd_busy)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (halted) state_next = DUMP;
            DUMP:    if (cnt == AW'(NREGS - 1)) state_next = DONE;
            DONE:    if (!halted) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Dump outputs are registered: each DUMP cycle emits one register and advances cnt.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt        <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                DUMP: begin
                    dump_valid <= 1'b1;
                    dump_idx   <= cnt;
                    dump_data  <= regs[cnt];
                    dump_done  <= 1'b0;
                    cnt        <= cnt + AW'(1);
                end
                DONE: begin
                    dump_valid <= 1'b0;
                    dump_done  <= halted;
                end
                default: begin
                    dump_valid <= 1'b0;
                    dump_done  <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Next generation of the core's single-write, dual-read register file.
- Adds:
  - configurable numbers of read and write ports;
  - optional write-to-read bypass;
  - a per-register busy scoreboard for the issue stage;
  - a cycle-by-cycle hardware dump engine triggered by halted, replacing the simulation-only dump.
- Sits between decode/issue (reads, marks) and writeback (writes) in the pipeline.

Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, >=2)
- NRD, 2, number of read ports
- NWR, 1, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- Localparam AW = $clog2(NREGS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_b  in  1  asynchronous, active-low reset
- rd_num  in  NRD*AW  packed read addresses; port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  packed read data, combinational
- rd_busy  out  NRD  scoreboard busy bit of each read address, combinational
- wr_we  in  NWR  per-port write enable
- wr_num  in  NWR*AW  packed write addresses
- wr_data  in  NWR*XLEN  packed write data
- mark_en  in  1  set busy for mark_num (instruction issued with destination)
- mark_num  in  AW  register to mark busy
- halted  in  1  core halted; starts dump
- dump_valid  out  1  dump_idx/dump_data valid this cycle
- dump_idx  out  AW  register index being dumped
- dump_data  out  XLEN  value of register dump_idx
- dump_done  out  1  dump complete; held while halted stays high

Behaviour:
- Reset (rst_b low, async):
  - all registers = 0, all busy bits = 0;
  - FSM = IDLE; dump_valid = 0, dump_idx = 0, dump_data = 0, dump_done = 0.
- Register 0:
  - always reads 0 and is never busy;
  - writes and marks to 0 are ignored.
- Write (FSM = IDLE only):
  - on a clock edge, each port with wr_we=1 and wr_num!=0 updates data[wr_num].
  - If several ports target the same register in one cycle, the highest-indexed port wins.
- Read, combinational:
  - BYPASS=1: if any enabled write port this cycle targets rd_num (!=0), return the winning port's wr_data; otherwise return the stored value.
  - BYPASS=0: stored value only (new value visible next cycle).
  - Bypass is active only in IDLE.
- Scoreboard:
  - An effective write to register r clears busy[r] at the edge.
  - mark_en sets busy[mark_num].
  - Mark and write to the same register in the same cycle: busy ends at 1 (the mark represents a newer producer).
  - rd_busy[i] = busy[rd_num_i]; it does not reflect the same-cycle clear.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE -> DUMP on the first edge where halted=1; the internal counter cnt is set to 0.
  - In DUMP, registered outputs each cycle: dump_valid=1, dump_idx=cnt, dump_data=data[cnt]; then cnt++.
  - After index NREGS-1 has been emitted: DUMP -> DONE. dump_valid=0 and dump_done=1 next cycle.
  - First dump_valid appears 1 cycle after halted rises; exactly NREGS consecutive valid cycles, indices ascending, no gaps.
  - DONE -> IDLE when halted=0; dump_done drops the same edge.
  - While in DUMP/DONE: wr_we and mark_en are ignored, giving a frozen snapshot. Reads still return stored values.
  - halted dropping during DUMP does not abort; the dump completes, then DONE -> IDLE on the next edge.
- Reset asserted mid-dump: immediately returns to IDLE with all state cleared. A re-dump requires halted high after reset.
- Address widths are exact AW bits; no out-of-range addresses exist.

Decomposition:
- Shared package regfile_pkg holds:
  - dump_state_t enum {IDLE, DUMP, DONE};
  - default XLEN/NREGS constants used by the core top.
- One natural sub-module: regfile_scoreboard (busy-bit array with set/clear priority and read lookup, parametrised by NREGS, NRD, NWR).
- Storage, bypass and dump FSM stay in regfile_mp.

Test Plan:
- Reset then read all ports -> rd_data=0, rd_busy=0. Write r5=0xDEADBEEF on port 0, read r5 next cycle -> 0xDEADBEEF. Write r0=0x1234 -> r0 reads 0.
- BYPASS=1: write r7=0xA5A5A5A5 with same-cycle read of r7 -> 0xA5A5A5A5 that cycle. BYPASS=0, same stimulus -> old value 0, then 0xA5A5A5A5 next cycle.
- NWR=2, both ports write r3 (port0=0x11, port1=0x22) -> r3=0x22. Port0 r4=0x44 with port1 r6=0x66 -> both stored.
- mark r9 -> rd_busy=1 next cycle. Write r9 -> busy cleared. Mark r9 and write r9 in the same cycle -> busy remains 1 and data updated. Mark r0 -> never busy.
- Load r1..r31 with value = index*0x10, raise halted -> 32 consecutive dump_valid cycles starting 1 cycle later, idx 0..31, data idx*0x10. Then dump_done=1. A write r1=0xFF during dump is ignored. halted low -> dump_done=0.
- Assert rst_b low at dump index 10 -> dump_valid=0, FSM IDLE, all registers 0. Raise halted again -> full dump of zeros.
